// File: rtl/i2c_slave_controller_if.sv
// rtl/i2c_slave_controller_if.sv - parallel-side bundle of the I2C slave controller
//
// Purpose: carries the byte-level data and status between the I2C slave and its host.
// Signals:
//   tx_data_in     [7:0]  byte returned to the bus master on a read
//   rx_data_out    [7:0]  last byte written by the bus master
//   rx_valid_out          one-cycle pulse when rx_data_out updates
//   addr_match_out        address ACKed, held until STOP/START
//   busy_out              high between START and STOP
// Modports: slave (the controller), master (the host side / bench).
interface i2c_slave_controller_if;
   logic [7:0] tx_data_in;
   logic [7:0] rx_data_out;
   logic       rx_valid_out;
   logic       addr_match_out;
   logic       busy_out;

   modport slave  (input  tx_data_in,
                   output rx_data_out, rx_valid_out, addr_match_out, busy_out);
   modport master (output tx_data_in,
                   input  rx_data_out, rx_valid_out, addr_match_out, busy_out);
endinterface

// File: rtl/i2c_slave_controller.sv
// rtl/i2c_slave_controller.sv - I2C slave with 7-bit address, multi-byte write and read
//
// Purpose: oversampled I2C slave; SCL/SDA are synchronized to i2c_clock_in and all
//          bus timing is derived from edges of the synchronized lines.
// Ports:
//   i2c_clock_in   system clock (>= 8x SCL)
//   i2c_reset_in   asynchronous active-high reset
//   i2c_scl_inout  serial clock, sampled only, never driven
//   i2c_sda_inout  serial data, open-drain (driven 0 or released)
//   bus            i2c_slave_controller_if.slave data/status bundle
module i2c_slave_controller #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic                         i2c_clock_in,
   input  logic                         i2c_reset_in,
   inout  wire                          i2c_scl_inout,
   inout  wire                          i2c_sda_inout,
   i2c_slave_controller_if.slave        bus
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
   } state_t;

   // Synchronizers: [0] is the metastability flop, [1] the usable value.
   logic [1:0] scl_sync, sda_sync;
   logic       scl_prev, sda_prev;
   logic [1:0] idle_cnt;
   logic       bus_ready;

   logic scl_s, sda_s;
   logic scl_rise, scl_fall, start_det, stop_det;

   state_t     state, state_n;
   logic [3:0] bit_cnt, bit_cnt_n;
   logic       byte_done, byte_done_n;   // 8 bits taken, waiting for the falling edge
   logic [7:0] shift, shift_n;
   logic [7:0] tx_shift, tx_shift_n;
   logic       rw, rw_n;
   logic       nack, nack_n;
   logic       sda_low, sda_low_n;
   logic [7:0] rx_data, rx_data_n;
   logic       rx_valid, rx_valid_n;
   logic       addr_match, addr_match_n;
   logic       busy, busy_n;

   assign i2c_scl_inout = 1'bz;
   assign i2c_sda_inout = sda_low ? 1'b0 : 1'bz;

   assign bus.rx_data_out    = rx_data;
   assign bus.rx_valid_out   = rx_valid;
   assign bus.addr_match_out = addr_match;
   assign bus.busy_out       = busy;

   assign scl_s    = scl_sync[1];
   assign sda_s    = sda_sync[1];
   assign scl_rise = scl_s & ~scl_prev;
   assign scl_fall = ~scl_s & scl_prev;
   // Bus conditions are only trusted once the lines have been seen idle after reset.
   assign start_det = bus_ready & scl_s & scl_prev & sda_prev & ~sda_s;
   assign stop_det  = bus_ready & scl_s & scl_prev & ~sda_prev & sda_s;

   always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
      if (i2c_reset_in) begin
         scl_sync  <= 2'b00;
         sda_sync  <= 2'b00;
         scl_prev  <= 1'b0;
         sda_prev  <= 1'b0;
         idle_cnt  <= 2'd0;
         bus_ready <= 1'b0;
      end else begin
         scl_sync <= {scl_sync[0], i2c_scl_inout};
         sda_sync <= {sda_sync[0], i2c_sda_inout};
         scl_prev <= scl_s;
         sda_prev <= sda_s;
         if (!bus_ready) begin
            if (scl_s && sda_s) begin
               idle_cnt <= idle_cnt + 2'd1;
               if (idle_cnt == 2'd1) bus_ready <= 1'b1;
            end else begin
               idle_cnt <= 2'd0;
            end
         end
      end
   end

   always_ff @(posedge i2c_clock_in or posedge i2c_reset_in) begin
      if (i2c_reset_in) begin
         state      <= IDLE;
         bit_cnt    <= 4'd0;
         byte_done  <= 1'b0;
         shift      <= 8'h00;
         tx_shift   <= 8'h00;
         rw         <= 1'b0;
         nack       <= 1'b0;
         sda_low    <= 1'b0;
         rx_data    <= 8'h00;
         rx_valid   <= 1'b0;
         addr_match <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         byte_done  <= byte_done_n;
         shift      <= shift_n;
         tx_shift   <= tx_shift_n;
         rw         <= rw_n;
         nack       <= nack_n;
         sda_low    <= sda_low_n;
         rx_data    <= rx_data_n;
         rx_valid   <= rx_valid_n;
         addr_match <= addr_match_n;
         busy       <= busy_n;
      end
   end

   always_comb begin
      state_n      = state;
      bit_cnt_n    = bit_cnt;
      byte_done_n  = byte_done;
      shift_n      = shift;
      tx_shift_n   = tx_shift;
      rw_n         = rw;
      nack_n       = nack;
      sda_low_n    = sda_low;
      rx_data_n    = rx_data;
      rx_valid_n   = 1'b0;
      addr_match_n = addr_match;
      busy_n       = busy;

      // START/STOP outrank any bit activity in the same cycle.
      if (start_det) begin
         state_n      = ADDR;
         bit_cnt_n    = 4'd0;
         byte_done_n  = 1'b0;
         shift_n      = 8'h00;
         sda_low_n    = 1'b0;
         busy_n       = 1'b1;
         addr_match_n = 1'b0;
      end else if (stop_det) begin
         state_n      = IDLE;
         bit_cnt_n    = 4'd0;
         byte_done_n  = 1'b0;
         sda_low_n    = 1'b0;
         busy_n       = 1'b0;
         addr_match_n = 1'b0;
      end else begin
         case (state)
            ADDR, WR_DATA: begin
               if (scl_rise) begin
                  shift_n = {shift[6:0], sda_s};
                  if (bit_cnt == 4'd7) begin
                     bit_cnt_n   = 4'd0;
                     byte_done_n = 1'b1;
                     if (state == WR_DATA) begin
                        rx_data_n  = {shift[6:0], sda_s};
                        rx_valid_n = 1'b1;
                     end
                  end else begin
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end else if (scl_fall && byte_done) begin
                  byte_done_n = 1'b0;
                  if (state == WR_DATA) begin
                     state_n   = WR_ACK;
                     sda_low_n = 1'b1;
                  end else if (shift[7:1] == SLAVE_ADDR) begin
                     state_n      = ADDR_ACK;
                     sda_low_n    = 1'b1;
                     addr_match_n = 1'b1;
                     rw_n         = shift[0];
                  end else begin
                     state_n = WAIT_STOP;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  if (rw) begin
                     tx_shift_n = bus.tx_data_in;
                     sda_low_n  = ~bus.tx_data_in[7];
                     state_n    = RD_DATA;
                  end else begin
                     sda_low_n = 1'b0;
                     state_n   = WR_DATA;
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_low_n = 1'b0;
                  state_n   = WR_DATA;
               end
            end
            RD_DATA: begin
               if (scl_rise) begin
                  if (bit_cnt == 4'd7) begin
                     bit_cnt_n   = 4'd0;
                     byte_done_n = 1'b1;
                  end else begin
                     bit_cnt_n = bit_cnt + 4'd1;
                  end
               end else if (scl_fall) begin
                  if (byte_done) begin
                     byte_done_n = 1'b0;
                     sda_low_n   = 1'b0;
                     state_n     = RD_ACK;
                  end else begin
                     tx_shift_n = {tx_shift[6:0], 1'b0};
                     sda_low_n  = ~tx_shift[6];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  nack_n = sda_s;
               end else if (scl_fall) begin
                  if (nack) begin
                     sda_low_n = 1'b0;
                     state_n   = WAIT_STOP;
                  end else begin
                     tx_shift_n = bus.tx_data_in;
                     sda_low_n  = ~bus.tx_data_in[7];
                     state_n    = RD_DATA;
                  end
               end
            end
            IDLE, WAIT_STOP: ;
            default: state_n = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave_controller.sv
// tb/tb_i2c_slave_controller.sv - directed bench for i2c_slave_controller
module tb_i2c_slave_controller;
   localparam int Q = 10;   // system cycles per quarter SCL period

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic scl_drv = 1'b1;    // 1 = released
   logic sda_drv = 1'b1;
   wire  scl, sda;

   assign scl = scl_drv ? 1'bz : 1'b0;
   assign sda = sda_drv ? 1'bz : 1'b0;
   pullup (scl);
   pullup (sda);

   i2c_slave_controller_if bus_if ();

   i2c_slave_controller #(.SLAVE_ADDR(7'h50)) dut (
      .i2c_clock_in  (clk),
      .i2c_reset_in  (rst),
      .i2c_scl_inout (scl),
      .i2c_sda_inout (sda),
      .bus           (bus_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int         vcnt = 0;
   logic [7:0] vlog [0:15];
   int         run = 0;
   int         bad_width = 0;
   int         sd_cnt = 0;     // cycles where SDA is low while the master releases it

   always @(negedge clk) begin
      if (bus_if.rx_valid_out === 1'b1) begin
         if (run == 0) begin
            vlog[vcnt % 16] = bus_if.rx_data_out;
            vcnt++;
         end
         run++;
      end else begin
         if (run > 1) bad_width++;
         run = 0;
      end
      if (sda === 1'b0 && sda_drv) sd_cnt++;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_cycle(input logic b, output logic s);
      sda_drv = b;
      tick(Q);
      scl_drv = 1'b1;
      tick(Q);
      s = sda;
      tick(Q);
      scl_drv = 1'b0;
      tick(Q);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; tick(Q);
      scl_drv = 1'b1; tick(Q);
      sda_drv = 1'b0; tick(Q);
      scl_drv = 1'b0; tick(Q);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; tick(Q);
      scl_drv = 1'b1; tick(Q);
      sda_drv = 1'b1; tick(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_cycle(d[i], s);
      bit_cycle(1'b1, ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic nack_bit, output logic line9);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_cycle(1'b1, s);
         d[i] = s;
      end
      bit_cycle(nack_bit, line9);
   endtask

   initial begin
      logic       ack, line9, s;
      logic [7:0] rd;
      int         v0, sd0;

      bus_if.tx_data_in = 8'h00;

      // Reset state
      tick(3);
      check("rst_rx_data", bus_if.rx_data_out, 8'h00);
      check("rst_rx_valid", {7'd0, bus_if.rx_valid_out}, 8'h00);
      check("rst_addr_match", {7'd0, bus_if.addr_match_out}, 8'h00);
      check("rst_busy", {7'd0, bus_if.busy_out}, 8'h00);
      check("rst_sda", {7'd0, sda}, 8'h01);
      rst = 1'b0;
      tick(Q);

      // Write 0x50+W, 0xA5, STOP
      v0 = vcnt;
      i2c_start();
      check("w1_busy_after_start", {7'd0, bus_if.busy_out}, 8'h01);
      write_byte(8'hA0, ack);
      check("w1_addr_ack", {7'd0, ack}, 8'h00);
      check("w1_addr_match", {7'd0, bus_if.addr_match_out}, 8'h01);
      write_byte(8'hA5, ack);
      check("w1_data_ack", {7'd0, ack}, 8'h00);
      check("w1_rx_data", bus_if.rx_data_out, 8'hA5);
      check("w1_valid_count", 8'(vcnt - v0), 8'd1);
      check("w1_busy_before_stop", {7'd0, bus_if.busy_out}, 8'h01);
      i2c_stop();
      check("w1_busy_after_stop", {7'd0, bus_if.busy_out}, 8'h00);
      check("w1_match_after_stop", {7'd0, bus_if.addr_match_out}, 8'h00);

      // Read 0x50+R returning 0x3C, master NACK, STOP
      bus_if.tx_data_in = 8'h3C;
      i2c_start();
      write_byte(8'hA1, ack);
      check("r1_addr_ack", {7'd0, ack}, 8'h00);
      bus_if.tx_data_in = 8'hFF;   // latched copy must still be sent
      read_byte(rd, 1'b1, line9);
      check("r1_data", rd, 8'h3C);
      check("r1_sda_released_9th", {7'd0, line9}, 8'h01);
      check("r1_busy_wait_stop", {7'd0, bus_if.busy_out}, 8'h01);
      sd0 = sd_cnt;
      i2c_stop();
      check("r1_busy_after_stop", {7'd0, bus_if.busy_out}, 8'h00);
      check("r1_no_drive_after_nack", 8'(sd_cnt - sd0), 8'd0);

      // Wrong address 0x51+W, data 0xFF
      v0  = vcnt;
      sd0 = sd_cnt;
      i2c_start();
      write_byte(8'hA2, ack);
      check("nm_addr_nack", {7'd0, ack}, 8'h01);
      check("nm_addr_match", {7'd0, bus_if.addr_match_out}, 8'h00);
      write_byte(8'hFF, ack);
      check("nm_data_nack", {7'd0, ack}, 8'h01);
      i2c_stop();
      check("nm_sda_never_low", 8'(sd_cnt - sd0), 8'd0);
      check("nm_no_valid", 8'(vcnt - v0), 8'd0);

      // Two-byte write 0x11, 0x22
      v0 = vcnt;
      i2c_start();
      write_byte(8'hA0, ack);
      check("mb_addr_ack", {7'd0, ack}, 8'h00);
      write_byte(8'h11, ack);
      check("mb_ack1", {7'd0, ack}, 8'h00);
      write_byte(8'h22, ack);
      check("mb_ack2", {7'd0, ack}, 8'h00);
      i2c_stop();
      check("mb_valid_count", 8'(vcnt - v0), 8'd2);
      check("mb_byte0", vlog[v0 % 16], 8'h11);
      check("mb_byte1", vlog[(v0 + 1) % 16], 8'h22);
      check("mb_pulse_width", 8'(bad_width), 8'd0);

      // Partial write byte, repeated START, read
      v0 = vcnt;
      i2c_start();
      write_byte(8'hA0, ack);
      check("rs_addr_ack", {7'd0, ack}, 8'h00);
      bit_cycle(1'b1, s);
      bit_cycle(1'b0, s);
      bit_cycle(1'b1, s);
      bit_cycle(1'b0, s);
      i2c_start();
      check("rs_match_cleared", {7'd0, bus_if.addr_match_out}, 8'h00);
      check("rs_busy", {7'd0, bus_if.busy_out}, 8'h01);
      bus_if.tx_data_in = 8'h96;
      write_byte(8'hA1, ack);
      check("rs_read_addr_ack", {7'd0, ack}, 8'h00);
      read_byte(rd, 1'b1, line9);
      check("rs_read_data", rd, 8'h96);
      i2c_stop();
      check("rs_no_valid", 8'(vcnt - v0), 8'd0);

      // Reset while the slave holds SDA low for the address ACK
      i2c_start();
      for (int i = 7; i >= 0; i--) bit_cycle(((8'hA0 >> i) & 8'h01) != 8'h00, s);
      sda_drv = 1'b1;
      tick(Q);
      check("rr_ack_driven", {7'd0, sda}, 8'h00);
      #3 rst = 1'b1;
      #1;
      check("rr_sda_released", {7'd0, sda}, 8'h01);
      check("rr_rx_data", bus_if.rx_data_out, 8'h00);
      check("rr_rx_valid", {7'd0, bus_if.rx_valid_out}, 8'h00);
      check("rr_addr_match", {7'd0, bus_if.addr_match_out}, 8'h00);
      check("rr_busy", {7'd0, bus_if.busy_out}, 8'h00);
      @(negedge clk);
      scl_drv = 1'b1; tick(2 * Q);
      scl_drv = 1'b0; tick(Q);
      rst = 1'b0;
      v0  = vcnt;
      sd0 = sd_cnt;
      write_byte(8'h33, ack);
      check("rr_rest_ignored_ack", {7'd0, ack}, 8'h01);
      check("rr_rest_busy", {7'd0, bus_if.busy_out}, 8'h00);
      check("rr_rest_no_drive", 8'(sd_cnt - sd0), 8'd0);
      check("rr_rest_no_valid", 8'(vcnt - v0), 8'd0);
      i2c_stop();

      // Normal operation after reset
      i2c_start();
      write_byte(8'hA0, ack);
      check("pr_addr_ack", {7'd0, ack}, 8'h00);
      write_byte(8'h5A, ack);
      check("pr_data_ack", {7'd0, ack}, 8'h00);
      i2c_stop();
      check("pr_rx_data", bus_if.rx_data_out, 8'h5A);
      check("pr_pulse_width", 8'(bad_width), 8'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/i2c_slave_controller.md
I2C_SLAVE_CONTROLLER -- requirements
Module: i2c_slave_controller

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, 7-bit bus address this block answers to.
REQ-002 i2c_clock_in  input  1  system clock; one clock only, at least 8x the SCL rate.
REQ-003 i2c_reset_in  input  1  reset, asynchronous and active-high.
REQ-004 i2c_scl_inout  inout  1  serial clock line; only sampled, always high-Z (no clock stretching).
REQ-005 i2c_sda_inout  inout  1  serial data line, open-drain.
REQ-006 tx_data_in  input  8  byte returned to the master on a read.
REQ-007 rx_data_out  output  8  last byte written by the master.
REQ-008 rx_valid_out  output  1  one-cycle pulse when rx_data_out is updated.
REQ-009 addr_match_out  output  1  high from address ACK until STOP/START.
REQ-010 busy_out  output  1  high between a detected START and the next STOP.

Function
REQ-011 SCL and SDA shall each pass through a 2-flop synchronizer; all edge and condition detection shall use the synchronized values.
REQ-012 START shall be detected when synchronized SDA falls while SCL is high, and STOP when SDA rises while SCL is high.
REQ-013 SDA shall only ever be driven to 0 or left high-Z, never driven to 1.
REQ-014 States: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-015 START in any state shall clear the bit counter, enter ADDR, set busy_out=1 and clear addr_match_out; this is the repeated-START case.
REQ-016 STOP in any state shall enter IDLE, release SDA, and clear busy_out and addr_match_out.
REQ-017 In ADDR and WR_DATA, SDA shall be sampled MSB-first on each SCL rising edge into an 8-bit shift register.
REQ-018 After the 8th address bit: on match of bits[7:1] with SLAVE_ADDR, enter ADDR_ACK at the next SCL falling edge, drive SDA=0, and set addr_match_out=1.
REQ-019 On address mismatch, enter WAIT_STOP and never drive SDA.
REQ-020 ADDR_ACK shall release SDA at the falling edge ending the 9th clock.
REQ-021 From ADDR_ACK with R/W=0, go to WR_DATA.
REQ-022 From ADDR_ACK with R/W=1, latch tx_data_in at that same falling edge, enter RD_DATA, and drive bit7.
REQ-023 After the 8th WR_DATA bit, rx_data_out shall update and rx_valid_out shall pulse for exactly one i2c_clock_in cycle, one cycle after the detected SCL rising edge.
REQ-024 WR_DATA shall then enter WR_ACK at the next falling edge, drive SDA=0 for one SCL period, and return to WR_DATA; multi-byte writes are supported.
REQ-025 In RD_DATA, the next bit shall be presented within 2 system cycles after each synchronized SCL falling edge.
REQ-026 After 8 bits, RD_DATA shall release SDA and enter RD_ACK.
REQ-027 In RD_ACK, master ACK=0 sampled on the rising edge shall reload tx_data_in at the next falling edge and continue RD_DATA.
REQ-028 In RD_ACK, NACK=1 shall enter WAIT_STOP with SDA released.
REQ-029 WAIT_STOP shall ignore data and leave only on START or STOP.
REQ-030 The bit counter shall be 4 bits wide, count 0-7 per byte, and wrap to 0 at each ACK phase.
REQ-031 A START or STOP occurring mid-byte shall take priority over bit sampling in the same cycle.

Reset
REQ-032 While i2c_reset_in=1: state=IDLE, SDA high-Z, rx_data_out=8'h00, rx_valid_out=0, addr_match_out=0, busy_out=0, counters and shift registers cleared; this applies immediately, without waiting for a clock edge.
REQ-033 After reset deasserts, no START shall be recognised until the synchronizers have seen SCL=1 and SDA=1 for 2 cycles.
REQ-034 Reset asserted mid-transfer shall release SDA within the same cycle and ignore the remainder of the transfer until a new START.

Verification
REQ-035 Write 0x50+W, data 0xA5, STOP -> ACK on both 9th clocks, rx_data_out=8'hA5, exactly one rx_valid_out pulse, busy_out 1->0 at STOP.
REQ-036 Read 0x50+R with tx_data_in=8'h3C, master NACK, STOP -> SDA bits 0,0,1,1,1,1,0,0, SDA released at the 9th clock, state WAIT_STOP then IDLE.
REQ-037 Address 0x51+W, data 0xFF -> SDA never driven low, addr_match_out=0, no rx_valid_out.
REQ-038 Write 0x50+W, 0x11, 0x22, STOP -> two rx_valid_out pulses carrying 8'h11 then 8'h22, three ACKs.
REQ-039 Write 0x50+W, 4 data bits, repeated START, 0x50+R -> partial byte discarded, no rx_valid_out, read proceeds with ACK.
REQ-040 Reset asserted during the ACK low phase -> SDA high-Z in the same cycle and all outputs at their reset values.
